video_unpacking: RTL

Read-side counterpart of the sampling path. Requests fixed-length bursts of 256-bit words from the DDR read arbiter, buffers them in a small internal FIFO, and unpacks each word into 16 RGB565 pixels. Pixels are driven out in step with display-timing DE/VS so a downscaled tile can be placed into the spliced output frame. Frame alignment is on the rising edge of `vs_in`, the same convention the write path uses.

---
 rtl/video_unpacking.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/video_unpacking.sv
// Read-side unpacker: fetches 256-bit bursts from the DDR read arbiter into
// a small FIFO and streams them out as RGB565 pixels aligned to DE/VS.
module video_unpacking #(
    parameter int         DQ_WIDTH   = 32,
    parameter logic [3:0] IMAGE_TAG  = 4'd1,
    parameter int         OUT_WIDTH  = 320,
    parameter int         OUT_HEIGHT = 180,
    parameter int         BURST_LEN  = 8,
    parameter int         FIFO_DEPTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  de_in,
    input  logic                  vs_in,
    output logic                  rd_req,
    output logic [3:0]            rd_id,
    input  logic                  rd_ack,
    input  logic                  rd_valid,
    input  logic [DQ_WIDTH*8-1:0] rd_data,
    output logic [15:0]           rgb565_out,
    output logic                  de_out,
    output logic                  vs_out,
    output logic                  underflow
);

    localparam int DW  = DQ_WIDTH * 8;
    localparam int WPF = OUT_WIDTH * OUT_HEIGHT / 16;
    localparam int WRW = $clog2(WPF + 1);
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int CW  = AW + 1;
    localparam int BW  = $clog2(BURST_LEN + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        RECV  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t         state, state_n;
    logic [BW-1:0]  beats, beats_n;
    logic [WRW-1:0] words_req, words_req_n;
    logic [DW-1:0]  mem [FIFO_DEPTH];
    logic [AW-1:0]  wr_ptr, rd_ptr;
    logic [CW-1:0]  count;
    logic [3:0]     sel;
    logic           vs_d1;
    logic           frame_active;
    logic           frame_start;
    logic           vs_fall;
    logic           has_data;
    logic           room;
    logic           push;
    logic           pop;
    logic [DW-1:0]  head;

    assign frame_start = vs_in & ~vs_d1;
    assign vs_fall     = ~vs_in & vs_d1;
    assign has_data    = (count != '0);
    assign room        = (CW'(FIFO_DEPTH) - count) >= CW'(BURST_LEN);
    assign push        = (state == RECV) & rd_valid & ~frame_start;
    assign pop         = de_in & has_data & (sel == 4'hF) & ~frame_start;
    assign head        = mem[rd_ptr];
    assign rd_req      = (state == REQ);
    assign rd_id       = rd_req ? IMAGE_TAG : 4'd0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vs_d1        <= 1'b0;
            frame_active <= 1'b0;
        end else begin
            vs_d1 <= vs_in;
            if (frame_start)
                frame_active <= 1'b0;
            else if (vs_fall)
                frame_active <= 1'b1;
        end
    end

    always_comb begin
        state_n     = state;
        beats_n     = beats;
        words_req_n = words_req;
        unique case (state)
            IDLE: begin
                if (!frame_start && frame_active &&
                    words_req < WRW'(WPF) && room)
                    state_n = REQ;
            end
            REQ: begin
                if (rd_ack) begin
                    words_req_n = words_req + WRW'(BURST_LEN);
                    beats_n     = BW'(BURST_LEN);
                    state_n     = frame_start ? DRAIN : RECV;
                end else if (frame_start) begin
                    state_n = IDLE;
                end
            end
            RECV: begin
                beats_n = beats - BW'(rd_valid);
                if (rd_valid && beats == BW'(1))
                    state_n = IDLE;
                else if (frame_start)
                    state_n = DRAIN;
            end
            DRAIN: begin
                // beats still owed by the arbiter are swallowed here
                beats_n = beats - BW'(rd_valid);
                if (rd_valid && beats == BW'(1))
                    state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            beats     <= '0;
            words_req <= '0;
        end else begin
            state     <= state_n;
            beats     <= beats_n;
            words_req <= frame_start ? '0 : words_req_n;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (frame_start) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= rd_data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rgb565_out <= '0;
            de_out     <= 1'b0;
            vs_out     <= 1'b0;
            underflow  <= 1'b0;
            sel        <= '0;
        end else begin
            de_out     <= de_in;
            vs_out     <= vs_in;
            rgb565_out <= (de_in && has_data) ? head[{sel, 4'b0} +: 16] : '0;
            priority case (1'b1)
                frame_start: begin
                    sel       <= '0;
                    underflow <= 1'b0;
                end
                de_in && has_data: sel <= sel + 4'd1;
                de_in:             underflow <= 1'b1;
                default: ;
            endcase
        end
    end

endmodule
